// File: rtl/reg_bank_pkg.sv
// Shared constants and helpers for the parametrised register bank.
// REG_BANK_PC_OFFSET_EN makes PC reads return pc_in + PC_READ_OFFSET.
package reg_bank_pkg;
   localparam int DEF_DATA_W     = 32;
   localparam int DEF_ADDR_W     = 4;
   localparam int DEF_PC_IDX     = 15;
   localparam int PC_READ_OFFSET = 8;

   // Low bit of port idx inside a flat ra/rd_data bus of field width w.
   function automatic int slice_lo(input int idx, input int w);
      return idx * w;
   endfunction
endpackage

// File: rtl/reg_bank_if.sv
// Decoder/writeback-side bus of the register bank: write, read, reserve and scoreboard signals.
interface reg_bank_if
   import reg_bank_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = 2
);
   localparam int NREG = 2**ADDR_W;

   logic                       we;
   logic [ADDR_W-1:0]          wa;
   logic [DATA_W-1:0]          wd;
   logic [DATA_W-1:0]          pc_in;
   logic [NUM_RD-1:0]          rd_en;
   logic [NUM_RD*ADDR_W-1:0]   ra;
   logic [NUM_RD*DATA_W-1:0]   rd_data;
   logic [NUM_RD-1:0]          rd_valid;
   logic                       rsv_en;
   logic [ADDR_W-1:0]          rsv_addr;
   logic [NREG-1:0]            busy;
   logic [NUM_RD-1:0]          hazard;

   modport master (
      output we, wa, wd, pc_in, rd_en, ra, rsv_en, rsv_addr,
      input  rd_data, rd_valid, busy, hazard
   );
   modport slave (
      input  we, wa, wd, pc_in, rd_en, ra, rsv_en, rsv_addr,
      output rd_data, rd_valid, busy, hazard
   );
endinterface

// File: rtl/reg_bank_rd_port.sv
// One registered read port: PC select, write-through bypass, storage mux and hazard term.
// REG_BANK_PC_OFFSET_EN adds PC_READ_OFFSET to the PC read view.
module reg_bank_rd_port
   import reg_bank_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int PC_IDX = DEF_PC_IDX,
   parameter int NREG   = 2**ADDR_W
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       rd_en,
   input  logic [ADDR_W-1:0]          ra,
   input  logic                       we,
   input  logic [ADDR_W-1:0]          wa,
   input  logic [DATA_W-1:0]          wd,
   input  logic [DATA_W-1:0]          pc_in,
   input  logic [NREG-1:0][DATA_W-1:0] regs,
   input  logic [NREG-1:0]            busy,
   output logic [DATA_W-1:0]          rd_data,
   output logic                       rd_valid,
   output logic                       hazard
);
   localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

   logic [DATA_W-1:0] pc_view;
   logic [DATA_W-1:0] sel;
   logic              hit_pc;
   logic              hit_wr;

`ifdef REG_BANK_PC_OFFSET_EN
   assign pc_view = pc_in + DATA_W'(PC_READ_OFFSET);
`else
   assign pc_view = pc_in;
`endif

   assign hit_pc = (ra == PC_A);
   assign hit_wr = we && (wa == ra);

   // PC beats the bypass so a (discarded) write to PC never leaks into a read.
   always_comb begin
      sel = regs[ra];
      if (hit_pc)
         sel = pc_view;
      else if (hit_wr)
         sel = wd;
   end

   assign hazard = rd_en & busy[ra] & ~hit_wr & ~hit_pc;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rd_data  <= '0;
         rd_valid <= 1'b0;
      end else begin
         rd_valid <= rd_en;
         if (rd_en)
            rd_data <= sel;
      end
   end
endmodule

// File: rtl/reg_bank_param.sv
// Parametrised register bank: storage, write/PC reload, pending-write scoreboard, NUM_RD read ports.
// REG_BANK_PC_OFFSET_EN (see reg_bank_rd_port) selects the ARM-style PC+8 read view.
module reg_bank_param
   import reg_bank_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int ADDR_W = DEF_ADDR_W,
   parameter int NUM_RD = 2,
   parameter int PC_IDX = DEF_PC_IDX
) (
   input  logic       clk,
   input  logic       rst_n,
   reg_bank_if.slave  bus
);
   localparam int                NREG = 2**ADDR_W;
   localparam logic [ADDR_W-1:0] PC_A = ADDR_W'(PC_IDX);

   logic [NREG-1:0][DATA_W-1:0]   regs;
   logic [NREG-1:0]               busy;
   logic [NREG-1:0]               busy_nxt;
   logic [NUM_RD-1:0][DATA_W-1:0] rd_data_a;
   logic                          wr_ok;

   assign wr_ok = bus.we && (bus.wa != PC_A);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         regs <= '0;
      end else begin
         if (wr_ok)
            regs[bus.wa] <= bus.wd;
         regs[PC_IDX] <= bus.pc_in;
      end
   end

   // Reservation applied after the write clear, so a same-address pair stays busy.
   always_comb begin
      busy_nxt = busy;
      if (wr_ok)
         busy_nxt[bus.wa] = 1'b0;
      if (bus.rsv_en && (bus.rsv_addr != PC_A))
         busy_nxt[bus.rsv_addr] = 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
         busy <= '0;
      else
         busy <= busy_nxt;
   end

   assign bus.busy    = busy;
   assign bus.rd_data = rd_data_a;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      reg_bank_rd_port #(
         .DATA_W (DATA_W),
         .ADDR_W (ADDR_W),
         .PC_IDX (PC_IDX),
         .NREG   (NREG)
      ) u_port (
         .clk      (clk),
         .rst_n    (rst_n),
         .rd_en    (bus.rd_en[i]),
         .ra       (bus.ra[slice_lo(i, ADDR_W) +: ADDR_W]),
         .we       (bus.we),
         .wa       (bus.wa),
         .wd       (bus.wd),
         .pc_in    (bus.pc_in),
         .regs     (regs),
         .busy     (busy),
         .rd_data  (rd_data_a[i]),
         .rd_valid (bus.rd_valid[i]),
         .hazard   (bus.hazard[i])
      );
   end
endmodule

// File: tb/tb_reg_bank_param.sv
// Scoreboard bench for reg_bank_param: default 32x16 2-port instance plus a 16-bit 8-reg 3-port instance.
module tb_reg_bank_param;
   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   reg_bank_if #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2)) ba();
   reg_bank_if #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3)) bb();

   reg_bank_param #(.DATA_W(32), .ADDR_W(4), .NUM_RD(2), .PC_IDX(15)) u_a (
      .clk(clk), .rst_n(rst_n), .bus(ba.slave));
   reg_bank_param #(.DATA_W(16), .ADDR_W(3), .NUM_RD(3), .PC_IDX(7)) u_b (
      .clk(clk), .rst_n(rst_n), .bus(bb.slave));

   typedef struct {
      int          port;
      logic [31:0] data;
   } exp_t;

   exp_t qa[$];
   exp_t qb[$];
   int   total = 0;
   int   bad   = 0;

   function automatic logic [31:0] pcv(input logic [31:0] p);
`ifdef REG_BANK_PC_OFFSET_EN
      return p + 32'd8;
`else
      return p;
`endif
   endfunction

   function automatic logic [15:0] pcv16(input logic [15:0] p);
`ifdef REG_BANK_PC_OFFSET_EN
      return p + 16'd8;
`else
      return p;
`endif
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_a();
      ba.we = 0; ba.wa = '0; ba.wd = '0; ba.rd_en = '0; ba.ra = '0;
      ba.rsv_en = 0; ba.rsv_addr = '0;
   endtask

   task automatic idle_b();
      bb.we = 0; bb.wa = '0; bb.wd = '0; bb.rd_en = '0; bb.ra = '0;
      bb.rsv_en = 0; bb.rsv_addr = '0;
   endtask

   // Ports must be issued in ascending order within a cycle.
   task automatic rd_a(input int p, input logic [3:0] a, input logic [31:0] e);
      exp_t x;
      ba.rd_en[p] = 1'b1;
      ba.ra[p*4 +: 4] = a;
      x.port = p; x.data = e;
      qa.push_back(x);
   endtask

   task automatic rd_b(input int p, input logic [2:0] a, input logic [15:0] e);
      exp_t x;
      bb.rd_en[p] = 1'b1;
      bb.ra[p*3 +: 3] = a;
      x.port = p; x.data = {16'h0, e};
      qb.push_back(x);
   endtask

   task automatic monitor_a();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int i = 0; i < 2; i++) begin
               if (ba.rd_valid[i]) begin
                  total++;
                  if (qa.size() == 0) begin
                     bad++;
                     $display("FAIL a_rd%0d unexpected valid: got %h expected none", i, ba.rd_data[i*32 +: 32]);
                  end else begin
                     e = qa.pop_front();
                     if (e.port != i || ba.rd_data[i*32 +: 32] !== e.data) begin
                        bad++;
                        $display("FAIL a_rd%0d: got port %0d data %h expected port %0d data %h",
                                 i, i, ba.rd_data[i*32 +: 32], e.port, e.data);
                     end
                  end
               end
            end
         end
      end
   endtask

   task automatic monitor_b();
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n) begin
            for (int i = 0; i < 3; i++) begin
               if (bb.rd_valid[i]) begin
                  total++;
                  if (qb.size() == 0) begin
                     bad++;
                     $display("FAIL b_rd%0d unexpected valid: got %h expected none", i, bb.rd_data[i*16 +: 16]);
                  end else begin
                     e = qb.pop_front();
                     if (e.port != i || {16'h0, bb.rd_data[i*16 +: 16]} !== e.data) begin
                        bad++;
                        $display("FAIL b_rd%0d: got port %0d data %h expected port %0d data %h",
                                 i, i, bb.rd_data[i*16 +: 16], e.port, e.data);
                     end
                  end
               end
            end
         end
      end
   endtask

   initial begin
      rst_n = 1'b0;
      idle_a(); idle_b();
      ba.pc_in = 32'h100;
      bb.pc_in = 16'h40;
      fork
         monitor_a();
         monitor_b();
      join_none

      // reset state
      tick(); tick();
      chk("rst_valid", {30'h0, ba.rd_valid}, 32'h0);
      chk("rst_data", ba.rd_data[31:0] | ba.rd_data[63:32], 32'h0);
      chk("rst_busy", {16'h0, ba.busy}, 32'h0);
      chk("rst_busy_b", {24'h0, bb.busy}, 32'h0);
      rst_n = 1'b1;

      // every non-PC register reads 0 after reset
      for (int a = 0; a < 14; a += 2) begin
         idle_a();
         rd_a(0, 4'(a), 32'h0);
         rd_a(1, 4'(a + 1), 32'h0);
         tick();
      end
      idle_a(); rd_a(0, 4'd14, 32'h0); tick();

      // plain write then read, valid for one cycle
      idle_a(); ba.we = 1; ba.wa = 4'd3; ba.wd = 32'hDEADBEEF; tick();
      idle_a(); rd_a(0, 4'd3, 32'hDEADBEEF); tick();
      idle_a(); tick();

      // same-cycle bypass, both ports on one address
      idle_a(); ba.we = 1; ba.wa = 4'd5; ba.wd = 32'h12345678;
      rd_a(0, 4'd5, 32'h12345678); rd_a(1, 4'd5, 32'h12345678); tick();
      idle_a(); rd_a(0, 4'd5, 32'h12345678); rd_a(1, 4'd3, 32'hDEADBEEF); tick();

      // PC: write to PC ignored, read returns pc view; wrap case
      idle_a(); ba.we = 1; ba.wa = 4'd15; ba.wd = 32'h1; tick();
      idle_a(); rd_a(0, 4'd15, pcv(32'h100)); rd_a(1, 4'd3, 32'hDEADBEEF); tick();
      idle_a(); ba.pc_in = 32'hFFFFFFFC; rd_a(0, 4'd15, pcv(32'hFFFFFFFC)); tick();
      ba.pc_in = 32'h100;

      // scoreboard
      idle_a(); ba.rsv_en = 1; ba.rsv_addr = 4'd7; tick();
      chk("busy_rsv7", {16'h0, ba.busy}, 32'h0080);
      idle_a(); rd_a(0, 4'd7, 32'h0); ba.ra[7:4] = 4'd7; #1;
      chk("hazard_rd7", {30'h0, ba.hazard}, 32'h1);
      tick();
      idle_a(); ba.we = 1; ba.wa = 4'd7; ba.wd = 32'hAA; rd_a(0, 4'd7, 32'hAA); #1;
      chk("hazard_wr7", {30'h0, ba.hazard}, 32'h0);
      tick();
      chk("busy_clr7", {16'h0, ba.busy}, 32'h0);
      idle_a(); ba.rsv_en = 1; ba.rsv_addr = 4'd7; ba.we = 1; ba.wa = 4'd7; ba.wd = 32'hBB; tick();
      chk("busy_rsv_wr_same", {16'h0, ba.busy}, 32'h0080);
      idle_a(); ba.rsv_en = 1; ba.rsv_addr = 4'd9; ba.we = 1; ba.wa = 4'd7; ba.wd = 32'hCC; tick();
      chk("busy_rsv_wr_diff", {16'h0, ba.busy}, 32'h0200);
      idle_a(); ba.rsv_en = 1; ba.rsv_addr = 4'd15; tick();
      chk("busy_rsv_pc", {16'h0, ba.busy}, 32'h0200);
      idle_a(); ba.rsv_en = 1; ba.rsv_addr = 4'd9; tick();
      chk("busy_rsv_again", {16'h0, ba.busy}, 32'h0200);
      idle_a(); rd_a(0, 4'd7, 32'hCC); rd_a(1, 4'd9, 32'h0); #1;
      chk("hazard_port1", {30'h0, ba.hazard}, 32'h2);
      tick();

      // reset mid-operation with reads in flight
      idle_a(); ba.rd_en = 2'b11; ba.ra = {4'd5, 4'd3}; tick();
      #1 rst_n = 1'b0;
      #1;
      chk("midrst_valid", {30'h0, ba.rd_valid}, 32'h0);
      chk("midrst_data", ba.rd_data[31:0] | ba.rd_data[63:32], 32'h0);
      chk("midrst_busy", {16'h0, ba.busy}, 32'h0);
      idle_a(); idle_b();
      tick();
      rst_n = 1'b1;
      idle_a(); rd_a(0, 4'd3, 32'h0); rd_a(1, 4'd5, 32'h0); tick();
      idle_a(); tick();

      // three-port 16-bit instance
      idle_b(); bb.we = 1; bb.wa = 3'd0; bb.wd = 16'h1111; tick();
      bb.wa = 3'd3; bb.wd = 16'h3333; tick();
      bb.wa = 3'd6; bb.wd = 16'h6666; tick();
      idle_b(); rd_b(0, 3'd0, 16'h1111); rd_b(1, 3'd3, 16'h3333); rd_b(2, 3'd6, 16'h6666); tick();
      idle_b(); rd_b(0, 3'd7, pcv16(16'h40)); rd_b(1, 3'd6, 16'h6666); rd_b(2, 3'd6, 16'h6666); tick();
      idle_b(); bb.rsv_en = 1; bb.rsv_addr = 3'd7; tick();
      chk("b_busy_rsv_pc", {24'h0, bb.busy}, 32'h0);
      idle_b(); bb.rsv_en = 1; bb.rsv_addr = 3'd2; tick();
      chk("b_busy_rsv2", {24'h0, bb.busy}, 32'h04);
      idle_b(); rd_b(2, 3'd2, 16'h0); #1;
      chk("b_hazard2", {29'h0, bb.hazard}, 32'h4);
      tick();
      idle_b(); tick(); tick();

      chk("a_queue_drained", qa.size(), 32'h0);
      chk("b_queue_drained", qb.size(), 32'h0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
